// File: rtl/tivi_video_pkg.sv
// ---------------------------------------------------------------------------
// tivi_video_pkg
//   Shared timing constants and helpers for the TIVI raster generator.
//   - Default 640x480@72 timing (31.5 MHz pixel clock, 832 x 520 totals).
//   - h_tot / v_tot derive raster totals from the porch/sync/active widths.
//   - COORD_W is the width of the pixel coordinate buses (totals <= 1024).
//   - sync_level maps an "in sync pulse" flag onto the pin polarity.
//   - timing_out_t bundles every registered raster output.
// ---------------------------------------------------------------------------
package tivi_video_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 128;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 28;

    function automatic int h_tot(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    function automatic int v_tot(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    // Pin level for a sync output: active_high=0 drives the pulse low.
    function automatic logic sync_level(input logic active, input bit active_high);
        return active_high ? active : ~active;
    endfunction

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               line_start;
        logic               frame_start;
    } timing_out_t;

endpackage

// File: rtl/tivi_lock_sync.sv
// ---------------------------------------------------------------------------
// tivi_lock_sync
//   Generic two-flop synchroniser for slow status bits crossing into the
//   local clock domain. Both stages clear to 0 on reset, so a synchronised
//   status reads "not ready" until the input has been stable for two edges.
//   Ports:
//     clock  in      destination clock
//     reset  in      asynchronous, active-high reset
//     d      in  W   asynchronous status input
//     q      out W   synchronised status
// ---------------------------------------------------------------------------
module tivi_lock_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tivi_video_timing.sv
// ---------------------------------------------------------------------------
// tivi_video_timing
//   Pixel-domain raster timing generator (default 640x480@72, 832x520).
//   The raster is held at (0,0) with idle outputs until the PLL lock has
//   been synchronised; it then counts from (0,0), so the first registered
//   output after lock is always a frame_start.
//   All outputs are registered one clock after the (hcnt, vcnt) state they
//   describe, so they are mutually aligned.
//   Ports:
//     clock        in   pixel clock
//     reset        in   asynchronous, active-high reset
//     locked       in   PLL lock, asynchronous to clock
//     hsync/vsync  out  syncs, polarity set by SYNC_ACTIVE_HIGH
//     de           out  display enable (visible pixels)
//     x, y         out  COORD_W raster position (also during blanking)
//     line_start   out  pulse at h=0
//     frame_start  out  pulse at h=0, v=0
//     vblank_irq   out  sticky vblank interrupt   (TIVI_VBLANK_IRQ_EN only)
//     irq_ack      in   clears vblank_irq          (TIVI_VBLANK_IRQ_EN only)
//   Build option: define TIVI_VBLANK_IRQ_EN to add the vblank interrupt.
//   Timing totals must not exceed 2**COORD_W (1024) in either direction.
// ---------------------------------------------------------------------------
module tivi_video_timing
    import tivi_video_pkg::*;
#(
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FP             = DEF_H_FP,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BP             = DEF_H_BP,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FP             = DEF_V_FP,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BP             = DEF_V_BP,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
`ifdef TIVI_VBLANK_IRQ_EN
    output logic               frame_start,
    output logic               vblank_irq,
    input  logic               irq_ack
`else
    output logic               frame_start
`endif
);

    localparam int H_TOT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Inclusive bounds keep every constant representable even when a
    // region ends exactly at 2**COORD_W.
    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_IDLE = sync_level(1'b0, SYNC_ACTIVE_HIGH);

    localparam timing_out_t IDLE_OUT = '{
        hsync:       SYNC_IDLE,
        vsync:       SYNC_IDLE,
        de:          1'b0,
        x:           '0,
        y:           '0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic               run;
    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               h_wrap;
    logic               v_wrap;
    timing_out_t        out_nxt;
    timing_out_t        out_q;

    tivi_lock_sync #(.W(1)) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (locked),
        .q     (run)
    );

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    // Raster counters. Dropping run parks them at (0,0) so a returning lock
    // always starts a complete frame instead of finishing a stale one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Decode of the current raster position. vsync is a function of vcnt
    // alone; because vcnt only moves on the h wrap, vsync edges land at h=0.
    always_comb begin
        out_nxt = IDLE_OUT;
        if (run) begin
            out_nxt.de          = (hcnt <= H_ACT_LAST) && (vcnt <= V_ACT_LAST);
            out_nxt.hsync       = sync_level((hcnt >= HS_FIRST) && (hcnt <= HS_LAST),
                                             SYNC_ACTIVE_HIGH);
            out_nxt.vsync       = sync_level((vcnt >= VS_FIRST) && (vcnt <= VS_LAST),
                                             SYNC_ACTIVE_HIGH);
            out_nxt.x           = hcnt;
            out_nxt.y           = vcnt;
            out_nxt.line_start  = (hcnt == '0);
            out_nxt.frame_start = (hcnt == '0) && (vcnt == '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= IDLE_OUT;
        end else begin
            out_q <= out_nxt;
        end
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign de          = out_q.de;
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;

`ifdef TIVI_VBLANK_IRQ_EN
    localparam logic [COORD_W-1:0] V_BLANK_FIRST = COORD_W'(V_ACTIVE);

    logic irq_set;
    logic irq_q;

    // Registered alongside the outputs for (0, V_ACTIVE). Set has priority
    // over ack so an ack arriving with a new vblank never loses the event.
    assign irq_set = run && (hcnt == '0) && (vcnt == V_BLANK_FIRST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (!run) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_tivi_video_timing.sv
module tb_tivi_video_timing;
    import tivi_video_pkg::*;

    // Reduced raster for the second instance so whole frames fit the run.
    localparam int SH_A = 16, SH_F = 4, SH_S = 6, SH_B = 6;
    localparam int SV_A = 12, SV_F = 2, SV_S = 2, SV_B = 4;

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               ls;
        logic               fs;
        logic               irq;
    } obs_t;

    typedef struct {
        string name;
        logic  lk;
        int    n;
        obs_t  exp;
    } vec_t;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic locked = 1'b0;
`ifdef TIVI_VBLANK_IRQ_EN
    logic irq_ack = 1'b0;
`endif
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    logic hs0, vs0, de0, ls0, fs0, irq0;
    logic hs1, vs1, de1, ls1, fs1, irq1;
    logic [COORD_W-1:0] x0, y0, x1, y1;

    tivi_video_timing dut0 (
        .clock(clock), .reset(reset), .locked(locked),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0),
`ifdef TIVI_VBLANK_IRQ_EN
        .frame_start(fs0), .vblank_irq(irq0), .irq_ack(irq_ack)
`else
        .frame_start(fs0)
`endif
    );

    tivi_video_timing #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_ACTIVE_HIGH(1'b0)
    ) dut1 (
        .clock(clock), .reset(reset), .locked(locked),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1),
`ifdef TIVI_VBLANK_IRQ_EN
        .frame_start(fs1), .vblank_irq(irq1), .irq_ack(irq_ack)
`else
        .frame_start(fs1)
`endif
    );

`ifndef TIVI_VBLANK_IRQ_EN
    assign irq0 = 1'b0;
    assign irq1 = 1'b0;
`endif

    obs_t obs0, obs1;
    assign obs0 = {hs0, vs0, de0, x0, y0, ls0, fs0, irq0};
    assign obs1 = {hs1, vs1, de1, x1, y1, ls1, fs1, irq1};

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    function automatic obs_t mk(input logic hs, input logic vs, input logic de,
                                input int x, input int y, input logic ls, input logic fs);
        obs_t o;
        o = {hs, vs, de, COORD_W'(x), COORD_W'(y), ls, fs, 1'b0};
        return o;
    endfunction

    // Reference model: p counts pixels since the synchronised lock came up;
    // the raster position is simply p folded by the line and frame totals.
    function automatic obs_t model(input longint p, input bit run,
                                   input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb);
        obs_t o;
        int ht, vt, h, v;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        o = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        if (run) begin
            h = int'(p % longint'(ht));
            v = int'((p / longint'(ht)) % longint'(vt));
            o.de = (h < ha) && (v < va);
            o.hs = !((h >= ha + hf) && (h < ha + hf + hw));
            o.vs = !((v >= va + vf) && (v < va + vf + vw));
            o.x  = COORD_W'(h);
            o.y  = COORD_W'(v);
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
        end
        return o;
    endfunction

    function automatic bit at_vblank(input longint p, input int ht, input int vt, input int va);
        return (p % longint'(ht) == 0) && ((p / longint'(ht)) % longint'(vt) == longint'(va));
    endfunction

    // Lock samples seen at each edge; the raster sees them two edges later.
    bit     hist[$] = '{1'b0, 1'b0};
    longint p = 0;
    bit     pend0 = 1'b0, pend1 = 1'b0;
    obs_t   exp0, exp1;

    always @(posedge clock or posedge reset) begin : ref_model
        bit   r, n0, n1;
        obs_t e0, e1;
        if (reset) begin
            hist  = '{1'b0, 1'b0};
            p     <= 0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            exp0  <= model(0, 1'b0, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                           DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
            exp1  <= model(0, 1'b0, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
        end else begin
            r = hist.pop_front();
            hist.push_back(locked);
            e0 = model(p, r, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                       DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
            e1 = model(p, r, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
            n0 = 1'b0;
            n1 = 1'b0;
`ifdef TIVI_VBLANK_IRQ_EN
            if (r) begin
                n0 = at_vblank(p, 832, 520, DEF_V_ACTIVE) ? 1'b1 : (irq_ack ? 1'b0 : pend0);
                n1 = at_vblank(p, SH_A + SH_F + SH_S + SH_B, SV_A + SV_F + SV_S + SV_B, SV_A)
                     ? 1'b1 : (irq_ack ? 1'b0 : pend1);
            end
`endif
            e0.irq = n0;
            e1.irq = n1;
            pend0 <= n0;
            pend1 <= n1;
            exp0  <= e0;
            exp1  <= e1;
            p     <= r ? p + 1 : 0;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            cmp("model_dut0", 64'(obs0), 64'(exp0));
            cmp("model_dut1", 64'(obs1), 64'(exp1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        obs_t idle;
        int   cnt, de_cnt, hs_cnt, fall_x, lines, de_lines, vs_cnt, fall_y;
        logic prev;
        bit   seen;
        int   cyc;

        idle = mk(1, 1, 0, 0, 0, 0, 0);
        // Small raster: hsync 20..25, line 32 clocks, vsync lines 14..15.
        vecs.push_back('{"idle_unlocked",   1'b0, 100, idle});
        vecs.push_back('{"sync_latency",    1'b1, 2,   idle});
        vecs.push_back('{"first_frame",     1'b1, 1,   mk(1, 1, 1, 0, 0, 1, 1)});
        vecs.push_back('{"second_pixel",    1'b1, 1,   mk(1, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{"hsync_start",     1'b1, 19,  mk(0, 1, 0, 20, 0, 0, 0)});
        vecs.push_back('{"hsync_last",      1'b1, 5,   mk(0, 1, 0, 25, 0, 0, 0)});
        vecs.push_back('{"hsync_end",       1'b1, 1,   mk(1, 1, 0, 26, 0, 0, 0)});
        vecs.push_back('{"line_last",       1'b1, 5,   mk(1, 1, 0, 31, 0, 0, 0)});
        vecs.push_back('{"line_wrap",       1'b1, 1,   mk(1, 1, 1, 0, 1, 1, 0)});
        vecs.push_back('{"line1_px1",       1'b1, 1,   mk(1, 1, 1, 1, 1, 0, 0)});
        vecs.push_back('{"drop_in_flight",  1'b0, 2,   mk(1, 1, 1, 3, 1, 0, 0)});
        vecs.push_back('{"drop_idle",       1'b0, 1,   idle});
        vecs.push_back('{"drop_hold",       1'b0, 10,  idle});
        vecs.push_back('{"relock_frame",    1'b1, 3,   mk(1, 1, 1, 0, 0, 1, 1)});

        #1 reset = 1'b1;
        chk_on = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            locked = vecs[i].lk;
            repeat (vecs[i].n) @(negedge clock);
            cmp(vecs[i].name, 64'(obs1), 64'(vecs[i].exp));
        end

        // One full default-timing line.
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clock);
            seen = ls0;
        end
        if (!seen) timeout("line_wait");
        cnt = 0; de_cnt = 0; hs_cnt = 0; fall_x = -1; prev = hs0;
        do begin
            if (de0) de_cnt++;
            if (!hs0) hs_cnt++;
            if (prev && !hs0) fall_x = int'(x0);
            prev = hs0;
            @(negedge clock);
            cnt++;
        end while (!ls0 && cnt < 2000);
        cmp("line_period", 64'(cnt), 64'(832));
        cmp("line_de_clocks", 64'(de_cnt), 64'(640));
        cmp("line_hsync_clocks", 64'(hs_cnt), 64'(40));
        cmp("hsync_fall_x", 64'(fall_x), 64'(664));

        // One full small-raster frame.
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clock);
            seen = fs1;
        end
        if (!seen) timeout("frame_wait");
        cnt = 0; lines = 0; de_lines = 0; vs_cnt = 0; fall_x = -1; fall_y = -1; prev = vs1;
        do begin
            if (ls1) lines++;
            if (ls1 && de1) de_lines++;
            if (!vs1) vs_cnt++;
            if (prev && !vs1) begin
                fall_x = int'(x1);
                fall_y = int'(y1);
            end
            prev = vs1;
            @(negedge clock);
            cnt++;
        end while (!fs1 && cnt < 2000);
        cmp("frame_lines", 64'(lines), 64'(20));
        cmp("frame_de_lines", 64'(de_lines), 64'(12));
        cmp("frame_vsync_clocks", 64'(vs_cnt), 64'(64));
        cmp("vsync_fall_y", 64'(fall_y), 64'(14));
        cmp("vsync_fall_x", 64'(fall_x), 64'(0));

`ifdef TIVI_VBLANK_IRQ_EN
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            seen = (y1 == 10'd12) && (x1 == 10'd0);
        end
        if (!seen) timeout("irq_set_wait");
        cmp("irq_rise", 64'(irq1), 64'(1));
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            seen = (y1 == 10'd17) && (x1 == 10'd5);
        end
        if (!seen) timeout("irq_ack_wait");
        irq_ack = 1'b1;
        @(negedge clock);
        irq_ack = 1'b0;
        cmp("irq_ack_clear", 64'(irq1), 64'(0));
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            seen = (y1 == 10'd11) && (x1 == 10'd31);
        end
        if (!seen) timeout("irq_hold_wait");
        irq_ack = 1'b1;
        @(negedge clock);
        cmp("irq_set_beats_ack", 64'(irq1), 64'(1));
        irq_ack = 1'b0;
`endif

        // Asynchronous reset inside vsync.
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            seen = (y1 == 10'd14) && (x1 == 10'd5);
        end
        if (!seen) timeout("vsync_wait");
        cmp("vsync_before_reset", 64'(vs1), 64'(0));
        #2 reset = 1'b1;
        #1;
        cmp("async_reset_dut1", 64'(obs1), 64'(idle));
        cmp("async_reset_dut0", 64'(obs0), 64'(idle));
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        cmp("frame_after_reset", 64'(obs1), 64'(mk(1, 1, 1, 0, 0, 1, 1)));

        // Randomised lock segments, acks and occasional resets.
        cyc = 0;
        while (cyc < 30000) begin
            int len;
            locked = ~locked;
            len = locked ? int'($urandom_range(1, 6000)) : int'($urandom_range(1, 40));
            repeat (len) begin
                @(negedge clock);
`ifdef TIVI_VBLANK_IRQ_EN
                irq_ack = ($urandom_range(0, 31) == 0);
`endif
                cyc++;
            end
            if ($urandom_range(0, 7) == 0) begin
                #2 reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tivi_video_timing.md
Name: tivi_video_timing

Overview:
- Pixel-clock-domain raster timing generator for the TIVI video path.
- Consumes the 31.5 MHz pixel clock and the PLL lock indication from the clock stage.
- Produces 640x480@72 Hz sync, display-enable and pixel coordinates for the pixel fetch/output stages.
- Raster does not run until the PLL lock has been synchronised into the pixel domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 128, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 28, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, sync polarity; 0 = syncs driven low during the pulse

Ports:
- clock  in  1  31.5 MHz pixel clock
- reset  in  1  asynchronous, active-high reset
- locked  in  1  PLL lock; asynchronous to clock
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- de  out  1  display enable; high on visible pixels
- x  out  10  horizontal counter value
- y  out  10  vertical counter value
- line_start  out  1  one-cycle pulse at h=0
- frame_start  out  1  one-cycle pulse at h=0, v=0
- vblank_irq  out  1  present only with TIVI_VBLANK_IRQ_EN
- irq_ack  in  1  present only with TIVI_VBLANK_IRQ_EN

Behaviour:
- Clock/reset: single clock domain; reset is asynchronous and active-high. All flops clear on reset.
- Output reset values: hsync/vsync at inactive level (1 when SYNC_ACTIVE_HIGH=0); de=0; x=0; y=0; line_start=0; frame_start=0; vblank_irq=0.
- Lock synchronisation: locked passes through a 2-flop synchroniser to give run. run is low during reset.
- Totals and counters:
  - H_TOT = 832, V_TOT = 520.
  - hcnt runs 0..H_TOT-1; vcnt runs 0..V_TOT-1.
  - Parameter constraint: H_TOT and V_TOT must each be ≤1024.
- run=0: hcnt and vcnt held at 0. Registered outputs take their reset values on the next clock.
- run=1: hcnt increments every clock.
  - At hcnt=H_TOT-1, hcnt wraps to 0 and vcnt increments.
  - At vcnt=V_TOT-1 with hcnt wrapping, vcnt wraps to 0.
- Lock lost mid-frame: counters return to 0 on the first clock with run=0. When run returns, counting restarts from (0,0) and a full frame follows, beginning with a frame_start pulse.
- Latency: every output is registered one clock after the (hcnt, vcnt) state it describes. All outputs are mutually aligned.
- Decode (applies only when run=1; otherwise outputs are idle):
  - de = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE)
  - hsync active for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 664..703
  - vsync active for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 489..491; vsync changes at the hcnt=0 boundary
  - x = hcnt and y = vcnt, unconditionally, including during blanking
  - line_start = (hcnt == 0); frame_start = (hcnt == 0 and vcnt == 0)
- Frame rate: 31.5e6 / (832 × 520) ≈ 72.8 Hz.

Optional Feature:
- Macro: TIVI_VBLANK_IRQ_EN.
- Defined:
  - vblank_irq sets on the registered cycle for hcnt=0, vcnt=V_ACTIVE, and stays high until irq_ack is sampled high.
  - Set and ack in the same cycle: set wins and vblank_irq remains 1.
  - A set while already pending is a no-op.
  - run=0 clears vblank_irq.
- Undefined: the vblank_irq and irq_ack ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package tivi_video_pkg holds:
  - default timing constants for 640x480@72;
  - derived H_TOT/V_TOT functions;
  - COORD_W=10;
  - the sync-polarity localparam helper.
- Sub-module tivi_lock_sync: generic 2-flop synchroniser with asynchronous active-high reset to 0. It is reused for other cross-domain status bits.

Test Plan:
- Lock ramp: reset 5 cycles with locked=0, release reset, keep locked=0 for 100 cycles → outputs idle (de=0, hsync=vsync=1, x=y=0). Raise locked → first frame_start exactly 3 clocks later (2 synchroniser + 1 output register), with x=0, y=0.
- Line timing: measure one line → 832 clocks between line_start pulses; de high for exactly 640 clocks; hsync low for 40 clocks; hsync falling edge on the cycle x=664.
- Frame timing: measure one frame → 520 line_start pulses between frame_starts; de present on 480 lines; vsync low for 3×832 clocks, starting at the cycle with y=489, x=0.
- Lock drop: deassert locked at x=300, y=200 → within 3 clocks x=y=0 and outputs idle. Reassert locked → clean frame_start; no short line is emitted.
- Async reset mid-frame: assert reset at an arbitrary point (y=490, vsync active) → all outputs reach reset values immediately, without a clock edge.
- IRQ (macro defined): vblank_irq rises with x=0, y=480. Pulse irq_ack at y=500 → vblank_irq clears. Hold irq_ack high across the next y=480 set cycle → vblank_irq is 1 after that cycle.
